// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-state data memory.
// Access sizes and controller state.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_waitstate_if.sv
// Request/response bundle between a load-store unit
// and the wait-state data memory.
interface dmem_waitstate_if #(
  parameter int ADDR_W = 11
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              misalign;
  logic              busy;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  rdata, ready, misalign, busy
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output rdata, ready, misalign, busy
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane merge for stores and lane extract/extend
// for loads on a little-endian 32-bit word.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_val,
  output logic        misalign
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b        = old_word[{lane, 3'b000} +: 8];
    h        = old_word[{lane[1], 4'b0000} +: 16];
    merged   = old_word;
    load_val = '0;
    misalign = 1'b0;
    unique case (1'b1)
      size == SZ_B: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        load_val = {{24{sext & b[7]}}, b};
      end
      size == SZ_H: begin
        misalign = lane[0];
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        load_val = {{16{sext & h[15]}}, h};
      end
      size == SZ_W: begin
        misalign = |lane;
        merged   = wdata;
        load_val = old_word;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_waitstate.sv
// Single-port data memory with a fixed response latency,
// one access in flight, sized and sign-extended accesses.
module dmem_waitstate
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_waitstate_if.slave   bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  logic [31:0] mem [0:(2**ADDR_W)-1] = '{default: '0};

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              mis_q, mis_d;
  logic              wr_en;

  logic [31:0] old_word, merged, load_val;
  logic        fmt_mis;

  assign old_word = mem[addr_q[ADDR_W+1:2]];

  dmem_lane_fmt u_fmt (
    .size     (size_q),
    .sext     (sext_q),
    .lane     (addr_q[1:0]),
    .old_word (old_word),
    .wdata    (wdata_q),
    .merged   (merged),
    .load_val (load_val),
    .misalign (fmt_mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    ready_d = 1'b0;
    mis_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          ready_d = 1'b1;
          mis_d   = fmt_mis;
          rdata_d = (we_q || fmt_mis) ? 32'd0 : load_val;
          wr_en   = we_q && !fmt_mis;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE
        if (bus.req) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          addr_d  = bus.addr;
          we_d    = bus.we;
          size_d  = bus.size;
          sext_d  = bus.sext;
          wdata_d = bus.wdata;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[addr_q[ADDR_W+1:2]] <= merged;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.misalign = mis_q;
  assign bus.busy     = (state_q == WAIT);
  assign dbg_data     = mem[dbg_addr];

endmodule

// File: doc/dmem_waitstate.md
DMEM_WAITSTATE -- requirements
Module: dmem_waitstate

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width; the array SHALL hold 2**ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal range 1..7; it is the number of clock edges from request acceptance to response.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  1  request strobe; sampled only when the block can accept.
REQ-006 we  in  1  1 = store, 0 = load.
REQ-007 size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 sext  in  1  load sign-extend (1) / zero-extend (0); ignored for word and store.
REQ-009 addr  in  ADDR_W+2  byte address; [1:0] = byte lane.
REQ-010 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rdata  out  32  formatted load result.
REQ-012 ready  out  1  one-cycle response pulse.
REQ-013 misalign  out  1  error flag, valid only while ready=1.
REQ-014 busy  out  1  high while a request is in flight.
REQ-015 dbg_addr  in  ADDR_W  debug word address.
REQ-016 dbg_data  out  32  combinational mem[dbg_addr].

Function
REQ-017 FSM states SHALL be IDLE, WAIT, DONE; busy SHALL equal (state==WAIT).
REQ-018 A request SHALL be accepted at an edge where req=1 and state is IDLE or DONE; addr, we, size, sext and wdata SHALL be latched at that edge.
REQ-019 On acceptance the FSM SHALL enter WAIT and load a counter with LATENCY-1.
REQ-020 In WAIT, the counter SHALL decrement each edge; at the edge where it is 0 the FSM SHALL enter DONE.
REQ-021 ready SHALL be 1 exactly in DONE; ready is therefore high in the cycle after the LATENCY-th edge following acceptance.
REQ-022 In DONE with req=0 the FSM SHALL return to IDLE; with req=1 it SHALL accept (REQ-018), giving a back-to-back throughput of one access per LATENCY+1 cycles.
REQ-023 req SHALL be ignored while busy=1; no queueing.
REQ-024 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11; misalign=1 for that response, no array write, rdata=0.
REQ-025 Stores SHALL commit at the edge entering DONE, writing only the addressed lanes (little-endian: lane 0 = bits 7:0; half at lane 0 or 2); other bytes unchanged.
REQ-026 Loads SHALL sample the array at the edge entering DONE; rdata = lane-extracted value, extended per sext.
REQ-027 For a store response rdata SHALL be 0; rdata and misalign SHALL be 0 whenever ready=0.
REQ-028 dbg_data SHALL reflect a committed store in the cycle following the commit edge.
REQ-029 Array contents SHALL be initialised to zero at time 0.

Reset
REQ-030 rst=1 at an edge SHALL force state IDLE, counter 0, ready 0, misalign 0, rdata 0, busy 0.
REQ-031 rst during WAIT SHALL abandon the access; a pending store SHALL NOT commit.
REQ-032 rst SHALL NOT clear array contents; rst and req together SHALL leave the request unaccepted.

Structure
REQ-033 Package dmem_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state enum.
REQ-034 Lane merge/extract logic SHALL be a combinational sub-module dmem_lane_fmt (inputs size, sext, addr[1:0], old word, wdata; outputs merged word, load value, misalign).

Verification
REQ-035 LATENCY=2: store word 0xDEADBEEF at addr 0x010 (req at edge 0) -> ready only in the cycle after edge 2, misalign=0, dbg_addr=4 gives 0xDEADBEEF.
REQ-036 Store byte 0x5A at addr 0x013 onto the above word -> word becomes 0x5AADBEEF; load byte signed at 0x013 -> 0x0000005A; load half signed at 0x012 -> 0x00005AAD. Load byte signed at 0x010 -> 0xFFFFFFEF; unsigned -> 0x000000EF.
REQ-037 Load word at 0x012 -> ready with misalign=1, rdata=0; store half at 0x011 -> misalign=1, memory unchanged.
REQ-038 req held high continuously, LATENCY=1 -> ready every second cycle; req asserted while busy=1 ignored.
REQ-039 Store issued, rst=1 in WAIT -> no ready, word at target address unchanged, busy=0 after the reset edge.
